// File: rtl/seg7_scan_driver_if.sv
// Purpose: bundles the datapath-side controls and the board-side display pins of seg7_scan_driver.
// Latency: none (wiring only); the driver registers its outputs one cycle behind its state.
// Backpressure: none; load is a level-sampled strobe and the display pins are free-running.
//
// Signal summary (NDIGITS digits):
//   load        datapath -> driver   capture strobe for value/dp_in
//   value       datapath -> driver   packed hex digits, digit i = value[4i+3:4i]
//   dp_in       datapath -> driver   decimal-point request per digit, 1 = lit
//   lzb         datapath -> driver   leading-zero blanking enable (live)
//   blink_en    datapath -> driver   whole-display blink enable (live)
//   seg         driver -> pins       segments a..g on bits 0..6, active-low
//   dp_n        driver -> pins       decimal point, active-low
//   an_n        driver -> pins       digit enables, active-low, one-cold
//   frame_tick  driver -> datapath   one-cycle pulse per completed scan frame
interface seg7_scan_driver_if #(
    parameter int NDIGITS = 4
) ();
    logic                   load;
    logic [4*NDIGITS-1:0]   value;
    logic [NDIGITS-1:0]     dp_in;
    logic                   lzb;
    logic                   blink_en;
    logic [6:0]             seg;
    logic                   dp_n;
    logic [NDIGITS-1:0]     an_n;
    logic                   frame_tick;

    // Datapath side: supplies the word to show, observes the display.
    modport master (
        output load,
        output value,
        output dp_in,
        output lzb,
        output blink_en,
        input  seg,
        input  dp_n,
        input  an_n,
        input  frame_tick
    );

    // Driver side.
    modport slave (
        input  load,
        input  value,
        input  dp_in,
        input  lzb,
        input  blink_en,
        output seg,
        output dp_n,
        output an_n,
        output frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexed common-anode 7-segment driver with leading-zero blanking, blink and frame tick.
// Latency: load -> shadow on the sampling edge, shown on the following edge; all pins are registered (1 cycle).
// Backpressure: none; load is level-sampled and recaptures every cycle it is held high.
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset, clears all state and forces the pins blank
//   bus  seg7_scan_driver_if.slave: load/value/dp_in/lzb/blink_en in, seg/dp_n/an_n/frame_tick out
module seg7_scan_driver #(
    parameter int NDIGITS   = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_driver_if.slave     bus
);

    localparam int SCW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int IDW = (NDIGITS   > 1) ? $clog2(NDIGITS)   : 1;
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
    localparam logic [IDW-1:0] IDX_LAST   = IDW'(NDIGITS - 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

    // Hex nibble to active-low segment pattern, a..g on bits 0..6.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h18;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SCW-1:0]          scan_cnt_q,    scan_cnt_d;
    logic [IDW-1:0]          idx_q,         idx_d;
    logic [BCW-1:0]          blink_cnt_q,   blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [4*NDIGITS-1:0]    shadow_val_q,  shadow_val_d;
    logic [NDIGITS-1:0]      shadow_dp_q,   shadow_dp_d;

    logic [6:0]              seg_q,         seg_d;
    logic                    dp_n_q,        dp_n_d;
    logic [NDIGITS-1:0]      an_n_q,        an_n_d;
    logic                    frame_tick_q,  frame_tick_d;

    logic                    scan_wrap;
    logic                    frame_wrap;
    logic [NDIGITS-1:0]      upper_zero;
    logic [3:0]              cur_nib;
    logic                    cur_blank;

    // ------------------------------------------------------------------
    // Scan, frame and blink timing
    // ------------------------------------------------------------------
    assign scan_wrap  = (scan_cnt_q == SCAN_LAST);
    // With a single digit idx is pinned at 0, so every slot wrap is also a frame wrap.
    assign frame_wrap = scan_wrap && (idx_q == IDX_LAST);

    always_comb begin
        scan_cnt_d    = scan_cnt_q + SCW'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        if (scan_wrap) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDW'(1);
        end

        // Blink timing runs regardless of blink_en so that enabling it
        // later does not restart the cadence.
        if (frame_wrap) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BCW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow capture: display logic never looks at the live value/dp_in.
    // ------------------------------------------------------------------
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (bus.load) begin
            shadow_val_d = bus.value;
            shadow_dp_d  = bus.dp_in;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero detection: upper_zero[i] is set when shadow nibbles
    // i..NDIGITS-1 are all zero.
    // ------------------------------------------------------------------
    always_comb begin
        upper_zero = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            upper_zero[i] = 1'b1;
            for (int j = i; j < NDIGITS; j++) begin
                if (shadow_val_q[4*j +: 4] != 4'h0) begin
                    upper_zero[i] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register next-state
    // ------------------------------------------------------------------
    always_comb begin
        cur_nib = shadow_val_q[4*int'(idx_q) +: 4];

        // Digit 0 is exempt from leading-zero blanking so an all-zero word still shows "0".
        cur_blank = (bus.blink_en && !blink_phase_q)
                 || (bus.lzb && (idx_q != '0) && upper_zero[idx_q]);

        seg_d        = 7'h7F;
        dp_n_d       = 1'b1;
        an_n_d       = '1;
        frame_tick_d = frame_wrap;

        if (!cur_blank) begin
            seg_d  = seg7_decode(cur_nib);
            dp_n_d = ~shadow_dp_q[idx_q];
            an_n_d = ~(NDIGITS'(1) << idx_q);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q    <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= 7'h7F;
            dp_n_q        <= 1'b1;
            an_n_q        <= '1;
            frame_tick_q  <= 1'b0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            an_n_q        <= an_n_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an_n       = an_n_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose: directed self-checking bench for seg7_scan_driver (NDIGITS=4, SCAN_DIV=4, BLINK_DIV=2).
// Latency: outputs sampled on the falling edge, one half-cycle after the registering edge.
// Backpressure: none; stimulus is driven on falling edges.
module tb_seg7_scan_driver;

    logic clk;
    logic rst;
    int   edge_n;        // rising edges since reset release
    int   n_checks;
    int   n_pass;

    seg7_scan_driver_if #(.NDIGITS(4)) dif ();

    seg7_scan_driver #(
        .NDIGITS   (4),
        .SCAN_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    // Segment table for hex 0..F, active-low.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Drive one load cycle; returns at the falling edge right after the capture edge.
    task automatic load_word(input logic [15:0] val, input logic [3:0] dp);
        dif.value = val;
        dif.dp_in = dp;
        dif.load  = 1'b1;
        @(negedge clk);
        dif.load  = 1'b0;
    endtask

    // Check n consecutive display cycles. Slot of edge k shows digit ((k-1)/4)%4;
    // a frame ends every 16 edges; the blink phase flips every 32 edges.
    task automatic run_check(input int n, input logic [15:0] val, input logic [3:0] dp,
                             input bit lz, input bit blk, input string tag);
        int         d;
        bit         blank;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            d     = ((edge_n - 1) / 4) % 4;
            blank = 1'b0;
            if (blk && ((((edge_n - 1) / 32) % 2) == 1)) blank = 1'b1;
            if (lz && (d > 0) && ((val >> (4 * d)) == 16'h0)) blank = 1'b1;
            if (blank) begin
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                exp_an  = ~(4'b0001 << d);
                exp_seg = seg_tab[val[4*d +: 4]];
                exp_dp  = ~dp[d];
            end
            chk({tag, "_an"},    32'(dif.an_n),       32'(exp_an));
            chk({tag, "_seg"},   32'(dif.seg),        32'(exp_seg));
            chk({tag, "_dp"},    32'(dif.dp_n),       32'(exp_dp));
            chk({tag, "_frame"}, 32'(dif.frame_tick), 32'((edge_n % 16) == 0));
        end
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        dif.load     = 1'b0;
        dif.value    = '0;
        dif.dp_in    = '0;
        dif.lzb      = 1'b0;
        dif.blink_en = 1'b0;

        // Reset state and first frame of 0x1234.
        repeat (3) @(negedge clk);
        chk("rst_an",    32'(dif.an_n),       32'hF);
        chk("rst_seg",   32'(dif.seg),        32'h7F);
        chk("rst_dp",    32'(dif.dp_n),       32'h1);
        chk("rst_frame", 32'(dif.frame_tick), 32'h0);
        rst = 1'b0;
        load_word(16'h1234, 4'b0000);
        // Edge 1 still shows the cleared shadow on digit 0.
        chk("first_an",  32'(dif.an_n), 32'hE);
        chk("first_seg", 32'(dif.seg),  32'h40);
        run_check(31, 16'h1234, 4'b0000, 1'b0, 1'b0, "frame1");

        // Decode sweep 0000, 1111, ... FFFF.
        for (int v = 0; v < 16; v++) begin
            load_word({4{4'(v)}}, 4'b0000);
            run_check(16, {4{4'(v)}}, 4'b0000, 1'b0, 1'b0, "sweep");
        end

        // Leading-zero blanking.
        dif.lzb = 1'b1;
        load_word(16'h0050, 4'b0000);
        run_check(16, 16'h0050, 4'b0000, 1'b1, 1'b0, "lzb50");
        load_word(16'h0000, 4'b0000);
        run_check(16, 16'h0000, 4'b0000, 1'b1, 1'b0, "lzb00");

        // Decimal point and load latency, load pulsed mid-slot.
        dif.lzb = 1'b0;
        for (int k = 0; k < 4 && (edge_n % 4) != 1; k++) @(negedge clk);
        load_word(16'hABCD, 4'b0100);
        chk("ld_old_seg", 32'(dif.seg),  32'h40);
        chk("ld_old_dp",  32'(dif.dp_n), 32'h1);
        run_check(16, 16'hABCD, 4'b0100, 1'b0, 1'b0, "ldabcd");

        // Blink: 32 visible / 32 blank cycles.
        dif.blink_en = 1'b1;
        run_check(128, 16'hABCD, 4'b0100, 1'b0, 1'b1, "blink");
        for (int k = 0; k < 64 && !(((((edge_n - 1) / 32) % 2) == 1) && (((edge_n / 32) % 2) == 1)); k++)
            @(negedge clk);
        chk("blink_off_pre", 32'(dif.an_n), 32'hF);
        dif.blink_en = 1'b0;
        run_check(16, 16'hABCD, 4'b0100, 1'b0, 1'b0, "blink_off");

        // Asynchronous reset while idx = 2.
        for (int k = 0; k < 32 && !(((edge_n % 4) == 2) && (((edge_n / 4) % 4) == 2)); k++)
            @(negedge clk);
        chk("pre_arst_an", 32'(dif.an_n), 32'hB);
        #2 rst = 1'b1;
        #1;
        chk("arst_an",    32'(dif.an_n),       32'hF);
        chk("arst_seg",   32'(dif.seg),        32'h7F);
        chk("arst_dp",    32'(dif.dp_n),       32'h1);
        chk("arst_frame", 32'(dif.frame_tick), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_check(32, 16'h0000, 4'b0000, 1'b0, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so a stalled run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
